// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard controller: tracking-entry layout,
// forward-select encoding and the saturating performance-counter helper.
package hazard_pkg;

    localparam int CNT_W  = 32;
    localparam int RD_W   = 8;   // widest supported register index (NREG up to 256)
    localparam int FWD_RF = 0;   // forward select: operand comes from the register file

    typedef struct packed {
        logic            valid;
        logic [RD_W-1:0] rd;
        logic            is_load;
    } entry_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value,
                                                 input logic             en);
        return (en && (value != '1)) ? value + CNT_W'(1) : value;
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-facing bundle of the hazard controller: ID/EX status in,
// stall/flush/forward-select decisions and performance counters out.
interface hazard_ctrl_if #(
    parameter int NREG  = 32,
    parameter int DEPTH = 3
);
    import hazard_pkg::*;

    localparam int RAW   = $clog2(NREG);
    localparam int SEL_W = $clog2(DEPTH);

    logic             id_valid;
    logic [RAW-1:0]   id_rs1;
    logic [RAW-1:0]   id_rs2;
    logic             id_rs1_used;
    logic             id_rs2_used;
    logic [RAW-1:0]   id_rd;
    logic             id_rd_wen;
    logic             id_is_load;
    logic             ex_redirect;

    logic             stall;
    logic             flush_ifid;
    logic             flush_idex;
    logic [SEL_W-1:0] fwd_a_sel;
    logic [SEL_W-1:0] fwd_b_sel;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               id_rd, id_rd_wen, id_is_load, ex_redirect,
        input  stall, flush_ifid, flush_idex, fwd_a_sel, fwd_b_sel,
               stall_cnt, flush_cnt
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               id_rd, id_rd_wen, id_is_load, ex_redirect,
        output stall, flush_ifid, flush_idex, fwd_a_sel, fwd_b_sel,
               stall_cnt, flush_cnt
    );

endinterface

// File: rtl/hazard_match.sv
// Youngest-match priority search of one source operand against the tracked
// stages; a WB-stage winner counts as a register-file read.
module hazard_match
    import hazard_pkg::*;
#(
    parameter int RAW      = 5,
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 2,
    parameter bit FWD_EN   = 1'b0
) (
    input  logic                       used,
    input  logic [RAW-1:0]             src,
    input  entry_t [DEPTH-1:0]         entries,
    output logic                       hit,
    output logic [$clog2(DEPTH)-1:0]   stage,
    output logic                       hazard
);
    localparam int SEL_W = $clog2(DEPTH);

    logic             found;
    logic [SEL_W-1:0] found_k;
    logic             found_load;

    always_comb begin
        // NOTE: every output of this block is defaulted first, so no path can leave it unassigned and infer a latch.
        found      = 1'b0;
        found_k    = '0;
        found_load = 1'b0;
        // Scan oldest to youngest so the smallest matching index is the last one written.
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (used && entries[k].valid && (entries[k].rd == RD_W'(src))) begin
                found      = 1'b1;
                found_k    = SEL_W'(k);
                found_load = entries[k].is_load;
            end
        end
    end

    assign hit    = found && (found_k != SEL_W'(DEPTH - 1));
    assign stage  = found_k;
    assign hazard = FWD_EN ? (hit && found_load && (int'(found_k) < LOAD_LAT - 1)) : hit;

endmodule

// File: rtl/hazard_ctrl.sv
// In-order pipeline hazard controller: RAW interlock, redirect flush and
// operand forward selects. Define HAZARD_CTRL_FORWARD_EN to enable forwarding.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int NREG     = 32,
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 2
) (
    input logic         clk,
    input logic         rst_n,
    hazard_ctrl_if.slave hz
);
    localparam int RAW   = $clog2(NREG);
    localparam int SEL_W = $clog2(DEPTH);

`ifdef HAZARD_CTRL_FORWARD_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    entry_t [DEPTH-1:0] pipe_q;
    entry_t             ent_d;
    logic               hit_a, hit_b;
    logic               haz_a, haz_b;
    logic               issue;
    logic [SEL_W-1:0]   stage_a, stage_b;
    logic [SEL_W-1:0]   sel_a_d, sel_b_d;
    logic [SEL_W-1:0]   sel_a_q, sel_b_q;
    logic [CNT_W-1:0]   stall_cnt_q, flush_cnt_q;

    hazard_match #(.RAW(RAW), .DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT), .FWD_EN(FWD_EN)) u_match_a (
        .used    (hz.id_rs1_used),
        .src     (hz.id_rs1),
        .entries (pipe_q),
        .hit     (hit_a),
        .stage   (stage_a),
        .hazard  (haz_a)
    );

    hazard_match #(.RAW(RAW), .DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT), .FWD_EN(FWD_EN)) u_match_b (
        .used    (hz.id_rs2_used),
        .src     (hz.id_rs2),
        .entries (pipe_q),
        .hit     (hit_b),
        .stage   (stage_b),
        .hazard  (haz_b)
    );

    // Redirect outranks the interlock: the stalled instruction is squashed anyway.
    assign hz.stall      = hz.id_valid && !hz.ex_redirect && (haz_a || haz_b);
    assign hz.flush_ifid = hz.ex_redirect;
    assign hz.flush_idex = hz.ex_redirect;
    assign issue         = hz.id_valid && !hz.stall && !hz.ex_redirect;

    always_comb begin
        ent_d   = '0;
        sel_a_d = SEL_W'(FWD_RF);
        sel_b_d = SEL_W'(FWD_RF);
        if (issue) begin
            ent_d.valid   = hz.id_rd_wen && (hz.id_rd != '0);
            ent_d.rd      = RD_W'(hz.id_rd);
            ent_d.is_load = hz.id_is_load;
            if (FWD_EN && hit_a) sel_a_d = stage_a + SEL_W'(1);
            if (FWD_EN && hit_b) sel_b_d = stage_b + SEL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignments so every register samples pre-edge values; reset is synchronous, tested inside the clocked block.
        if (!rst_n) begin
            // NOTE: the whole tracking register is cleared; a stale valid entry would raise a false stall right after release.
            pipe_q      <= '0;
            sel_a_q     <= '0;
            sel_b_q     <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            pipe_q      <= {pipe_q[DEPTH-2:0], ent_d};
            sel_a_q     <= sel_a_d;
            sel_b_q     <= sel_b_d;
            stall_cnt_q <= sat_inc(stall_cnt_q, hz.stall);
            flush_cnt_q <= sat_inc(flush_cnt_q, hz.ex_redirect);
        end
    end

    assign hz.fwd_a_sel = sel_a_q;
    assign hz.fwd_b_sel = sel_b_q;
    assign hz.stall_cnt = stall_cnt_q;
    assign hz.flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (NREG=32, DEPTH=3, LOAD_LAT=2);
// expectations follow HAZARD_CTRL_FORWARD_EN as defined for the build.
module tb_hazard_ctrl;

    logic clk;
    logic rst_n;
    int   tests_run;
    int   tests_failed;

    hazard_ctrl_if #(.NREG(32), .DEPTH(3)) hz ();

    hazard_ctrl #(.NREG(32), .DEPTH(3), .LOAD_LAT(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs1, input logic u1,
                          input logic [4:0] rs2, input logic u2,
                          input logic [4:0] rd, input logic wen, input logic ld);
        hz.id_valid    = v;
        hz.id_rs1      = rs1;
        hz.id_rs1_used = u1;
        hz.id_rs2      = rs2;
        hz.id_rs2_used = u2;
        hz.id_rd       = rd;
        hz.id_rd_wen   = wen;
        hz.id_is_load  = ld;
    endtask

    task automatic idle();
        set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        hz.ex_redirect = 1'b0;
    endtask

    // Inputs are already applied; check combinational outputs, clock once, check selects.
    task automatic cycle(input string tag, input logic e_stall, input logic e_flush,
                         input int e_a, input int e_b);
        #2;
        check({tag, ".stall"},      32'(hz.stall),      32'(e_stall));
        check({tag, ".flush_ifid"}, 32'(hz.flush_ifid), 32'(e_flush));
        check({tag, ".flush_idex"}, 32'(hz.flush_idex), 32'(e_flush));
        @(posedge clk);
        #1;
        check({tag, ".fwd_a_sel"},  32'(hz.fwd_a_sel),  32'(e_a));
        check({tag, ".fwd_b_sel"},  32'(hz.fwd_b_sel),  32'(e_b));
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".stall"},     32'(hz.stall),      32'd0);
        check({tag, ".flush"},     32'(hz.flush_ifid), 32'd0);
        check({tag, ".fwd_a_sel"}, 32'(hz.fwd_a_sel),  32'd0);
        check({tag, ".fwd_b_sel"}, 32'(hz.fwd_b_sel),  32'd0);
        check({tag, ".stall_cnt"}, hz.stall_cnt,       32'd0);
        check({tag, ".flush_cnt"}, hz.flush_cnt,       32'd0);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        idle();
        @(posedge clk);
        do_reset();
        check_all_zero("reset");

        // add x5, then a reader of x5
        set_id(1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0);
        cycle("t1_prod", 0, 0, 0, 0);
        set_id(1, 5'd5, 1, 5'd0, 0, 5'd9, 1, 0);
`ifdef HAZARD_CTRL_FORWARD_EN
        cycle("t1_cons", 0, 0, 1, 0);
`else
        cycle("t1_cons0", 1, 0, 0, 0);
        cycle("t1_cons1", 1, 0, 0, 0);
        cycle("t1_cons2", 0, 0, 0, 0);
`endif
        // x9 is now in EX, but nothing valid sits in ID
        set_id(0, 5'd9, 1, 5'd9, 1, 5'd0, 0, 0);
        cycle("t1_novalid", 0, 0, 0, 0);
`ifdef HAZARD_CTRL_FORWARD_EN
        check("t1_stall_cnt", hz.stall_cnt, 32'd0);
`else
        check("t1_stall_cnt", hz.stall_cnt, 32'd2);
`endif

        // lw x6, then add reading x6 on rs2
        do_reset();
        set_id(1, 5'd1, 1, 5'd0, 0, 5'd6, 1, 1);
        cycle("t2_lw", 0, 0, 0, 0);
        set_id(1, 5'd3, 1, 5'd6, 1, 5'd10, 1, 0);
`ifdef HAZARD_CTRL_FORWARD_EN
        cycle("t2_stall", 1, 0, 0, 0);
        cycle("t2_go", 0, 0, 0, 2);
        check("t2_stall_cnt", hz.stall_cnt, 32'd1);
`else
        cycle("t2_stall0", 1, 0, 0, 0);
        cycle("t2_stall1", 1, 0, 0, 0);
        cycle("t2_go", 0, 0, 0, 0);
        check("t2_stall_cnt", hz.stall_cnt, 32'd2);
`endif

        // writer of x0 never creates a hazard
        do_reset();
        set_id(1, 5'd1, 0, 5'd2, 0, 5'd0, 1, 0);
        cycle("t3_prod", 0, 0, 0, 0);
        set_id(1, 5'd0, 1, 5'd0, 1, 5'd11, 1, 0);
        cycle("t3_cons", 0, 0, 0, 0);

        // load-use coincident with a redirect: no stall, flush, bubble enters
        do_reset();
        set_id(1, 5'd1, 1, 5'd0, 0, 5'd6, 1, 1);
        cycle("t4_lw", 0, 0, 0, 0);
        set_id(1, 5'd3, 1, 5'd6, 1, 5'd10, 1, 0);
        hz.ex_redirect = 1'b1;
        cycle("t4_redir", 0, 1, 0, 0);
        hz.ex_redirect = 1'b0;
        set_id(1, 5'd10, 1, 5'd0, 0, 5'd12, 1, 0);
        cycle("t4_bubble", 0, 0, 0, 0);
        check("t4_flush_cnt", hz.flush_cnt, 32'd1);
        check("t4_stall_cnt", hz.stall_cnt, 32'd0);

        // the branch in EX (writing x7) survives its own redirect
        do_reset();
        set_id(1, 5'd1, 1, 5'd2, 1, 5'd7, 1, 0);
        cycle("t5_jal", 0, 0, 0, 0);
        hz.ex_redirect = 1'b1;
        set_id(1, 5'd7, 1, 5'd0, 0, 5'd13, 1, 0);
        cycle("t5_redir", 0, 1, 0, 0);
        hz.ex_redirect = 1'b0;
        set_id(1, 5'd7, 1, 5'd0, 0, 5'd14, 1, 0);
`ifdef HAZARD_CTRL_FORWARD_EN
        cycle("t5_cons", 0, 0, 2, 0);
`else
        cycle("t5_cons0", 1, 0, 0, 0);
        cycle("t5_cons1", 0, 0, 0, 0);
`endif

        // lw x9 then add x9: the younger add wins for both operands
        do_reset();
        set_id(1, 5'd1, 1, 5'd2, 1, 5'd9, 1, 1);
        cycle("t6_lw", 0, 0, 0, 0);
        set_id(1, 5'd3, 1, 5'd4, 1, 5'd9, 1, 0);
        cycle("t6_add", 0, 0, 0, 0);
        set_id(1, 5'd9, 1, 5'd9, 1, 5'd15, 1, 0);
`ifdef HAZARD_CTRL_FORWARD_EN
        cycle("t6_cons", 0, 0, 1, 1);
`else
        cycle("t6_cons0", 1, 0, 0, 0);
        cycle("t6_cons1", 1, 0, 0, 0);
        cycle("t6_cons2", 0, 0, 0, 0);
`endif

        // reset taken in the middle of a load-use stall
        do_reset();
        set_id(1, 5'd1, 1, 5'd0, 0, 5'd6, 1, 1);
        cycle("t7_lw", 0, 0, 0, 0);
        set_id(1, 5'd3, 1, 5'd6, 1, 5'd10, 1, 0);
        #2;
        check("t7_stall_before", 32'(hz.stall), 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle("t7_after", 0, 0, 0, 0);
        check("t7_stall_cnt", hz.stall_cnt, 32'd0);

        // counter saturation, then a one-edge reset
        do_reset();
        force dut.stall_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.stall_cnt_q;
        set_id(1, 5'd1, 1, 5'd0, 0, 5'd6, 1, 1);
        cycle("t8_lw0", 0, 0, 0, 0);
        set_id(1, 5'd6, 1, 5'd0, 0, 5'd6, 1, 1);
`ifdef HAZARD_CTRL_FORWARD_EN
        cycle("t8_s1", 1, 0, 0, 0);
        cycle("t8_g1", 0, 0, 2, 0);
        cycle("t8_s2", 1, 0, 0, 0);
        cycle("t8_g2", 0, 0, 2, 0);
`else
        for (int r = 0; r < 2; r++) begin
            cycle("t8_s1", 1, 0, 0, 0);
            cycle("t8_s2", 1, 0, 0, 0);
            cycle("t8_g", 0, 0, 0, 0);
        end
`endif
        check("t8_stall_sat", hz.stall_cnt, 32'hFFFF_FFFF);
        idle();
        force dut.flush_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.flush_cnt_q;
        hz.ex_redirect = 1'b1;
        cycle("t8_redir", 0, 1, 0, 0);
        hz.ex_redirect = 1'b0;
        check("t8_flush_sat", hz.flush_cnt, 32'hFFFF_FFFF);
        check("t8_stall_hold", hz.stall_cnt, 32'hFFFF_FFFF);
        do_reset();
        check_all_zero("t8_reset");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter NREG, default 32: architectural register count; RAW = $clog2(NREG) is the register index width.
REQ-002 Parameter DEPTH, default 3: tracked stages from EX to WB inclusive; index 0 = EX, index DEPTH-1 = WB; legal range 3..8.
REQ-003 Parameter LOAD_LAT, default 2: first stage index at which a load result can be forwarded; legal range 1..DEPTH-1.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 id_valid  in  1  a real instruction sits in IF/ID.
REQ-007 id_rs1, id_rs2  in  RAW each  source register indices of the ID instruction.
REQ-008 id_rs1_used, id_rs2_used  in  1 each  the source is actually read.
REQ-009 id_rd  in  RAW  destination register index; id_rd_wen  in  1  destination is written.
REQ-010 id_is_load  in  1  the ID instruction is a load.
REQ-011 ex_redirect  in  1  a taken branch or jump is resolving in EX this cycle.
REQ-012 stall  out  1  hold PC and IF/ID, and insert a bubble into ID/EX.
REQ-013 flush_ifid, flush_idex  out  1 each  squash the IF/ID and ID/EX contents.
REQ-014 fwd_a_sel, fwd_b_sel  out  $clog2(DEPTH) each  registered operand source selects for the instruction now in EX: 0 = register file, k+1 = result of tracked stage k+1.
REQ-015 stall_cnt, flush_cnt  out  32 each  performance counters.

Function
REQ-016 The block SHALL keep a DEPTH-entry shift register; each entry holds {valid, rd, is_load}, and the register advances every cycle.
REQ-017 Each cycle, entry 0 SHALL load the ID instruction when issue = id_valid & ~stall & ~ex_redirect; otherwise entry 0 SHALL load a bubble (valid = 0).
REQ-018 An entry SHALL be valid only when id_rd_wen = 1 and id_rd != 0 at issue; register x0 SHALL never cause a hazard.
REQ-019 A source SHALL match entry k when that source is used, the entry is valid, its rd equals the source index, and k < DEPTH-1.
REQ-020 Among matching entries, the youngest (smallest k) SHALL win.
REQ-021 A WB-stage match (k = DEPTH-1) SHALL be treated as a register-file read; the register file writes before it reads within a cycle.
REQ-022 With forwarding enabled, stall SHALL be asserted if a winning match is a load with k < LOAD_LAT-1.
REQ-023 With forwarding enabled and no stall, fwd_x_sel SHALL be registered as k+1 of the winning match, or 0 when there is no match; the selects update when issue is high.
REQ-024 When a bubble is inserted, fwd_a_sel and fwd_b_sel SHALL be registered as 0.
REQ-025 stall and the flush outputs SHALL be combinational, with zero-cycle latency from the ID and EX inputs.
REQ-026 When ex_redirect = 1, flush_ifid = flush_idex = 1 and stall = 0 in the same cycle; redirect has priority over stall.
REQ-027 The EX-stage entry (the branch itself) SHALL NOT be cleared by a redirect.
REQ-028 stall_cnt SHALL increment in each cycle where stall = 1.
REQ-029 flush_cnt SHALL increment in each cycle where ex_redirect = 1.
REQ-030 Both counters SHALL saturate at 32'hFFFFFFFF.
REQ-031 With id_valid = 0, stall SHALL be 0.

Reset
REQ-032 While rst_n = 0 at a clock edge, all entries SHALL become invalid, fwd_a_sel = fwd_b_sel = 0, and stall_cnt = flush_cnt = 0.
REQ-033 Reset asserted mid-stall or mid-flush SHALL abort the operation; in the first cycle after release, stall = 0 unless the inputs demand it.

Configuration
REQ-034 Macro HAZARD_CTRL_FORWARD_EN defined: forwarding per REQ-022..REQ-024.
REQ-035 Macro HAZARD_CTRL_FORWARD_EN undefined: stall SHALL be asserted on any match with k < DEPTH-1, and fwd_a_sel = fwd_b_sel = 0 constantly.

Structure
REQ-036 Package hazard_pkg SHALL hold the entry struct typedef, the forward-select encoding constants (FWD_RF = 0) and the counter width constant (32).
REQ-037 One sub-module, hazard_match, SHALL implement the combinational youngest-match priority search; it is instantiated once per source operand.

Verification
REQ-038 Defaults: issue add x5 (rd = 5), then issue add using rs1 = 5 on the next cycle -> stall = 0 and fwd_a_sel = 1 in the consumer's EX cycle.
REQ-039 Defaults: issue lw x6, then add using rs2 = 6 immediately -> stall = 1 for exactly one cycle, then fwd_b_sel = 2 and stall_cnt = 1.
REQ-040 Producer rd = 0 followed by a consumer of rs1 = 0 -> stall = 0 and fwd_a_sel = 0.
REQ-041 Load-use stall coincident with ex_redirect = 1 -> stall = 0, both flushes = 1, and entry 0 holds a bubble next cycle; flush_cnt increments.
REQ-042 HAZARD_CTRL_FORWARD_EN undefined, DEPTH = 3: add x7 then a consumer of x7 -> stall = 1 for 2 cycles, and sel = 0 throughout.
REQ-043 Preload stall_cnt to 32'hFFFFFFFF via forced stalls -> the counter holds its value; rst_n = 0 for one edge -> all outputs return to 0.
